// File: rtl/gpio_input_irq.sv
// -----------------------------------------------------------------------------
// gpio_input_irq
//
// Purpose:
//   Samples WIDTH asynchronous input pins, qualifies them into a "stable"
//   value, detects rising/falling edges of that stable value and latches
//   enabled edges into a PENDING register that drives a level interrupt.
//
// Register map (address[3:2]):
//   0 DATA    RO   stable pin value
//   1 RISE_EN RW   per-pin rising-edge enable
//   2 FALL_EN RW   per-pin falling-edge enable
//   3 PENDING R/W1C latched edge events
//
// Bus handshake: single-cycle strobes with no wait states. read_data is
//   combinational and valid in the same cycle read=1 (0 otherwise); a write
//   takes effect at the rising edge where write=1. A read in the same cycle as
//   a write returns the pre-write contents.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      synchronous active-low reset
//   read       bus read strobe
//   write      bus write strobe
//   address    register select (only bits [3:2] decoded)
//   write_data write payload
//   read_data  register read value, zero-extended
//   pins       asynchronous external inputs
//   irq        OR of PENDING, driven purely from registers
//
// Configuration:
//   GPIO_INPUT_DEBOUNCE_EN  when defined, a pin must differ from the stable
//   value for DEBOUNCE_CYCLES consecutive synchronized samples before stable
//   follows it. When undefined, stable follows the synchronizer every cycle.
// -----------------------------------------------------------------------------
module gpio_input_irq #(
    parameter int WIDTH           = 20,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    input  logic [WIDTH-1:0] pins,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] rise_evt;
    logic [WIDTH-1:0] fall_evt;
    logic [WIDTH-1:0] pend_set;
    logic [WIDTH-1:0] pend_clr;
    logic [1:0]       reg_sel;
    logic             wr_rise;
    logic             wr_fall;
    logic             wr_pend;

    assign reg_sel = address[3:2];
    assign wr_rise = write && (reg_sel == 2'd1);
    assign wr_fall = write && (reg_sel == 2'd2);
    assign wr_pend = write && (reg_sel == 2'd3);

    // Two-flop synchronizer: nothing downstream ever looks at pins directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

`ifdef GPIO_INPUT_DEBOUNCE_EN
    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] cnt     [WIDTH];
    logic [7:0] cnt_nxt [WIDTH];

    // The counter measures how long sync2 has disagreed with stable. Any
    // agreement restarts it, so a pulse shorter than DEBOUNCE_CYCLES samples
    // never reaches CNT_MAX and is dropped.
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = 8'd0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (!rst_n) begin
                cnt[i] <= 8'd0;
            end else begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end
`else
    assign stable_nxt = sync2;
`endif

    // Edges are taken from the upcoming stable value so that PENDING sets on
    // the same clock edge that stable changes.
    assign rise_evt = ~stable & stable_nxt;
    assign fall_evt = stable & ~stable_nxt;
    assign pend_set = (rise_evt & rise_en) | (fall_evt & fall_en);
    assign pend_clr = wr_pend ? write_data[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable  <= '0;
            rise_en <= '0;
            fall_en <= '0;
            pending <= '0;
        end else begin
            stable <= stable_nxt;
            if (wr_rise) begin
                rise_en <= write_data[WIDTH-1:0];
            end
            if (wr_fall) begin
                fall_en <= write_data[WIDTH-1:0];
            end
            // Clear first, then OR in new events: a set on the same edge wins.
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

    assign irq = |pending;

    always_comb begin
        read_data = '0;
        if (read) begin
            case (reg_sel)
                2'd0:    read_data[WIDTH-1:0] = stable;
                2'd1:    read_data[WIDTH-1:0] = rise_en;
                2'd2:    read_data[WIDTH-1:0] = fall_en;
                default: read_data[WIDTH-1:0] = pending;
            endcase
        end
    end

    // Address bits outside [3:2] and payload bits above WIDTH are don't-care.
    logic unused_bits;
    assign unused_bits = ^{address[31:4], address[1:0], write_data[31:WIDTH]};

endmodule

// File: doc/gpio_input_irq.md
GPIO_INPUT_IRQ -- requirements
Module: gpio_input_irq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 20, giving the number of input pins (1..31).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the debounce qualification length in clk cycles (2..255).
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port read, input, 1 bit: bus read strobe.
REQ-006 The block SHALL have port write, input, 1 bit: bus write strobe.
REQ-007 The block SHALL have port address, input, 32 bits: register select; only address[3:2] decoded.
REQ-008 The block SHALL have port write_data, input, 32 bits: write payload.
REQ-009 The block SHALL have port read_data, output, 32 bits: register read value.
REQ-010 The block SHALL have port pins, input, WIDTH bits: asynchronous external inputs.
REQ-011 The block SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-012 Register map (address[3:2]) SHALL be: 0 DATA (RO, stable pin value), 1 RISE_EN (RW), 2 FALL_EN (RW), 3 PENDING (read; write-1-to-clear).
REQ-013 read_data SHALL be combinational: selected register zero-extended to 32 bits when read=1, else 32'h0; bits [31:WIDTH] always 0.
REQ-014 Writes to DATA SHALL be ignored; writes to RISE_EN/FALL_EN SHALL load write_data[WIDTH-1:0] on the rising edge where write=1.
REQ-015 Each pin SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-016 Per pin, a stable register SHALL hold the qualified value; DATA returns stable.
REQ-017 Per pin, a rising edge SHALL be stable 0->1 and a falling edge stable 1->0, detected on the same clock edge that stable updates.
REQ-018 PENDING[i] SHALL set on a rising edge of pin i when RISE_EN[i]=1, or on a falling edge when FALL_EN[i]=1.
REQ-019 Writing PENDING with write_data[i]=1 SHALL clear PENDING[i]; write_data[i]=0 SHALL leave it unchanged.
REQ-020 Simultaneous set and clear of the same PENDING bit on one edge: set SHALL win (bit remains 1).
REQ-021 Clearing RISE_EN/FALL_EN SHALL NOT clear already-pending bits.
REQ-022 irq SHALL equal OR-reduction of PENDING, driven from registers (no combinational path from pins).
REQ-023 Simultaneous read and write SHALL return pre-write register contents on read_data.

Reset
REQ-024 While rst_n=0 at a rising edge: sync1, sync2, stable, RISE_EN, FALL_EN, PENDING, debounce counters SHALL clear to 0; irq SHALL be 0 the following cycle.
REQ-025 Reset asserted mid-qualification SHALL discard the partial count; no edge SHALL be reported from pre-reset activity.
REQ-026 A pin held high through reset SHALL produce a rising edge after reset; it sets PENDING only if RISE_EN was written to 1 before that edge.

Configuration
REQ-027 Macro GPIO_INPUT_DEBOUNCE_EN SHALL select debounce logic.
REQ-028 Without GPIO_INPUT_DEBOUNCE_EN: stable SHALL load sync2 every cycle; a pin change meeting setup before edge k SHALL appear in stable at edge k+2 (visible from cycle after).
REQ-029 With GPIO_INPUT_DEBOUNCE_EN: per-pin counter SHALL reset to 0 when sync2==stable, else increment; when it reaches DEBOUNCE_CYCLES-1 with sync2!=stable, stable SHALL load sync2 and counter SHALL return to 0.
REQ-030 With the macro, a change held steady SHALL reach stable at edge k+1+DEBOUNCE_CYCLES; pulses shorter than DEBOUNCE_CYCLES cycles at sync2 SHALL be ignored.

Verification
REQ-031 Reset, pins=0, write RISE_EN=0x1, pin0 0->1 (no debounce) -> DATA bit0=1 after 3 edges, PENDING=0x1, irq=1.
REQ-032 PENDING=0x1, write PENDING=0x1 -> PENDING=0, irq=0 next cycle; write 0x0 instead -> PENDING unchanged.
REQ-033 FALL_EN=0x2, pin1 falls on same edge that PENDING is written 0x2 -> PENDING[1]=1 (set wins).
REQ-034 Debounce enabled, DEBOUNCE_CYCLES=4, 3-cycle pulse on pin2 -> DATA and PENDING unchanged; 4-cycle-held change -> DATA[2] updates at edge k+5.
REQ-035 Pin3 edge in progress, rst_n=0 one cycle -> all registers 0, irq=0, no pending after release.
REQ-036 read=0 with any address -> read_data=0; read address 0xC with WIDTH=20 -> bits [31:20]=0.
